// File: rtl/ddr2_rd_capture.sv
// DDR2 read-return capture: grants read bursts against a credit limit and packs
// pairs of PHY beats into full-width words for the read FIFO.
module ddr2_rd_capture #(
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned WRITE_BURST     = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    wr_clk,
    input  logic                    reset,
    input  logic                    rd_cmd_req,
    output logic                    rd_cmd_ack,
    input  logic [DATA_WIDTH/2-1:0] phy_rd_data,
    input  logic                    phy_rd_vd,
    input  logic                    fifo_almost_full,
    output logic [DATA_WIDTH-1:0]   rd_fifo_in,
    output logic                    rd_fifo_vd,
    output logic                    busy,
    output logic                    rd_err
);

    localparam int unsigned HalfW = DATA_WIDTH / 2;
    localparam int unsigned CntW  = (WRITE_BURST > 2) ? $clog2(WRITE_BURST) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(WRITE_BURST - 1);
    localparam logic [3:0]      MaxOut   = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    state_e                state_q, state_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  hi_q, hi_d;
    logic [HalfW-1:0]      low_q, low_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  vd_q, vd_d;
    logic                  err_q, err_d;
    logic                  beat_ok;
    logic                  last_beat;

    always_comb begin
        rd_cmd_ack    = rd_cmd_req & ~reset & (outstanding_q < MaxOut) & ~fifo_almost_full;
        // Beats are only owned by a granted burst; in idle there is none.
        beat_ok       = phy_rd_vd & (state_q != StIdle);
        last_beat     = beat_ok & (beat_cnt_q == LastBeat);

        state_d       = state_q;
        outstanding_d = outstanding_q;
        beat_cnt_d    = beat_cnt_q;
        hi_d          = hi_q;
        low_d         = low_q;
        word_d        = word_q;
        vd_d          = 1'b0;
        err_d         = err_q;

        if (phy_rd_vd && !beat_ok) begin
            err_d = 1'b1;
        end

        if (beat_ok) begin
            if (hi_q) begin
                word_d = {phy_rd_data, low_q};
                vd_d   = 1'b1;
            end else begin
                low_d = phy_rd_data;
            end
            hi_d       = ~hi_q;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end

        unique case ({rd_cmd_ack, last_beat})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (rd_cmd_ack) begin
                    state_d = StWait;
                end
            end
            StWait, StBurst: begin
                if (last_beat) begin
                    state_d = (outstanding_d == 4'd0) ? StIdle : StWait;
                end else if (beat_ok) begin
                    state_d = StBurst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            hi_q          <= 1'b0;
            low_q         <= '0;
            word_q        <= '0;
            vd_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            hi_q          <= hi_d;
            low_q         <= low_d;
            word_q        <= word_d;
            vd_q          <= vd_d;
            err_q         <= err_d;
        end
    end

    assign rd_fifo_in = word_q;
    assign rd_fifo_vd = vd_q;
    assign busy       = (outstanding_q != 4'd0);
    assign rd_err     = err_q;

endmodule

// File: tb/tb_ddr2_rd_capture.sv
// Self-checking bench for ddr2_rd_capture: directed scenarios plus a randomized
// run against a credit/beat-count reference model.
module tb_ddr2_rd_capture;

    localparam int DW = 128;
    localparam int HW = 64;
    localparam int WB = 8;
    localparam int MO = 4;

    logic          wr_clk = 1'b0;
    logic          reset;
    logic          rd_cmd_req;
    logic          rd_cmd_ack;
    logic [HW-1:0] phy_rd_data;
    logic          phy_rd_vd;
    logic          fifo_almost_full;
    logic [DW-1:0] rd_fifo_in;
    logic          rd_fifo_vd;
    logic          busy;
    logic          rd_err;

    int errors = 0;
    int checks = 0;

    always #5 wr_clk = ~wr_clk;

    ddr2_rd_capture #(
        .DATA_WIDTH(DW),
        .WRITE_BURST(WB),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .wr_clk(wr_clk),
        .reset(reset),
        .rd_cmd_req(rd_cmd_req),
        .rd_cmd_ack(rd_cmd_ack),
        .phy_rd_data(phy_rd_data),
        .phy_rd_vd(phy_rd_vd),
        .fifo_almost_full(fifo_almost_full),
        .rd_fifo_in(rd_fifo_in),
        .rd_fifo_vd(rd_fifo_vd),
        .busy(busy),
        .rd_err(rd_err)
    );

    // Drive one cycle; ack is sampled before the edge, outputs are read 1ns after it.
    task automatic step(input logic req, input logic vd, input logic [HW-1:0] d,
                        input logic af, output logic ack);
        rd_cmd_req       = req;
        phy_rd_vd        = vd;
        phy_rd_data      = d;
        fifo_almost_full = af;
        #1;
        ack = rd_cmd_ack;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rd_cmd_req       = 1'b0;
        phy_rd_vd        = 1'b0;
        phy_rd_data      = '0;
        fifo_almost_full = 1'b0;
        reset            = 1'b1;
        @(posedge wr_clk);
        #1;
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rd_cmd_req       = 1'b1;
        phy_rd_vd        = 1'b0;
        phy_rd_data      = '0;
        fifo_almost_full = 1'b0;
        reset            = 1'b1;
        #2;
        checks++; if (rd_cmd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", rd_cmd_ack); end
        @(posedge wr_clk);
        #1;
        checks++; if (rd_fifo_vd !== 1'b0) begin errors++; $display("FAIL reset_vd: got %b want 0", rd_fifo_vd); end
        checks++; if (rd_fifo_in !== '0) begin errors++; $display("FAIL reset_in: got %h want 0", rd_fifo_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rd_err); end
        rd_cmd_req = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_single_burst();
        logic a;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_on: got %b want 1", busy); end
        for (int i = 1; i <= WB; i++) begin
            step(1'b0, 1'b1, 64'(i), 1'b0, a);
            checks++;
            if (rd_fifo_vd !== ((i % 2) == 0)) begin
                errors++; $display("FAIL single_vd beat %0d: got %b want %b", i, rd_fifo_vd, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                checks++;
                if (rd_fifo_in !== {64'(i), 64'(i - 1)}) begin
                    errors++; $display("FAIL single_word beat %0d: got %h want %h", i, rd_fifo_in, {64'(i), 64'(i - 1)});
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_off: got %b want 0", busy); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", rd_err); end
        step(1'b0, 1'b0, '0, 1'b0, a);
        checks++; if (rd_fifo_vd !== 1'b0) begin errors++; $display("FAIL hold_vd: got %b want 0", rd_fifo_vd); end
        checks++;
        if (rd_fifo_in !== {64'd8, 64'd7}) begin
            errors++; $display("FAIL hold_in: got %h want %h", rd_fifo_in, {64'd8, 64'd7});
        end
    endtask

    task automatic test_credit_limit();
        logic a;
        int   acks  = 0;
        int   words = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, a);
            if (a === 1'b1) acks++;
        end
        rd_cmd_req = 1'b0;
        checks++; if (acks != MO) begin errors++; $display("FAIL credit_acks: got %0d want %0d", acks, MO); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL credit_busy: got %b want 1", busy); end
        for (int b = 0; b < MO * WB; b++) begin
            step(1'b0, 1'b1, 64'(b + 100), 1'b0, a);
            if (rd_fifo_vd === 1'b1) words++;
        end
        checks++; if (words != MO * WB / 2) begin errors++; $display("FAIL credit_words: got %0d want %0d", words, MO * WB / 2); end
        checks++;
        if (rd_fifo_in !== {64'd131, 64'd130}) begin
            errors++; $display("FAIL credit_last_word: got %h want %h", rd_fifo_in, {64'd131, 64'd130});
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL credit_drained: got %b want 0", busy); end
    endtask

    task automatic test_almost_full();
        logic a;
        int   acks  = 0;
        int   words = 0;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL af_first_ack: got %b want 1", a); end
        for (int i = 0; i < WB; i++) begin
            step(1'b1, 1'b1, 64'(i + 50), 1'b1, a);
            if (a === 1'b1) acks++;
            if (rd_fifo_vd === 1'b1) words++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL af_acks: got %0d want 0", acks); end
        checks++; if (words != WB / 2) begin errors++; $display("FAIL af_words: got %0d want %0d", words, WB / 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL af_busy: got %b want 0", busy); end
        step(1'b0, 1'b0, '0, 1'b0, a);
    endtask

    task automatic test_ack_on_last();
        logic a;
        int   acks  = 0;
        int   words = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, a);
            if (a === 1'b1) acks++;
        end
        checks++; if (acks != 2) begin errors++; $display("FAIL aol_setup_acks: got %0d want 2", acks); end
        for (int i = 0; i < WB - 1; i++) step(1'b0, 1'b1, 64'(i), 1'b0, a);
        step(1'b1, 1'b1, 64'(WB - 1), 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL aol_ack: got %b want 1", a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aol_busy: got %b want 1", busy); end
        // Two credits must remain free if outstanding stayed at 2.
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, a);
            if (a === 1'b1) acks++;
        end
        checks++; if (acks != 2) begin errors++; $display("FAIL aol_free_credits: got %0d want 2", acks); end
        for (int b = 0; b < MO * WB; b++) begin
            step(1'b0, 1'b1, 64'(b), 1'b0, a);
            if (rd_fifo_vd === 1'b1) words++;
        end
        checks++; if (words != MO * WB / 2) begin errors++; $display("FAIL aol_words: got %0d want %0d", words, MO * WB / 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aol_drained: got %b want 0", busy); end
    endtask

    task automatic test_unsolicited();
        logic a;
        do_reset();
        step(1'b0, 1'b1, 64'hdead, 1'b0, a);
        checks++; if (rd_fifo_vd !== 1'b0) begin errors++; $display("FAIL unsol_vd: got %b want 0", rd_fifo_vd); end
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL unsol_err: got %b want 1", rd_err); end
        step(1'b0, 1'b0, '0, 1'b0, a);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL unsol_sticky: got %b want 1", rd_err); end
        step(1'b1, 1'b0, '0, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL unsol_ack: got %b want 1", a); end
        for (int i = 1; i <= WB; i++) begin
            step(1'b0, 1'b1, 64'(i + 512), 1'b0, a);
            if ((i % 2) == 0) begin
                checks++;
                if (rd_fifo_vd !== 1'b1 || rd_fifo_in !== {64'(i + 512), 64'(i + 511)}) begin
                    errors++;
                    $display("FAIL unsol_word beat %0d: got vd=%b %h want vd=1 %h", i, rd_fifo_vd,
                             rd_fifo_in, {64'(i + 512), 64'(i + 511)});
                end
            end
        end
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL unsol_err_end: got %b want 1", rd_err); end
    endtask

    task automatic test_reset_mid_burst();
        logic a;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, a);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 64'(i + 16), 1'b0, a);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmb_busy: got %b want 0", busy); end
        checks++; if (rd_fifo_vd !== 1'b0) begin errors++; $display("FAIL rmb_vd: got %b want 0", rd_fifo_vd); end
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, a);
        step(1'b0, 1'b1, 64'h301, 1'b0, a);
        checks++; if (rd_fifo_vd !== 1'b0) begin errors++; $display("FAIL rmb_stray: got %b want 0", rd_fifo_vd); end
        step(1'b0, 1'b1, 64'h302, 1'b0, a);
        checks++;
        if (rd_fifo_vd !== 1'b1 || rd_fifo_in !== {64'h302, 64'h301}) begin
            errors++; $display("FAIL rmb_first_word: got vd=%b %h want vd=1 %h", rd_fifo_vd, rd_fifo_in, {64'h302, 64'h301});
        end
        for (int i = 3; i <= WB; i++) step(1'b0, 1'b1, 64'(i + 'h300), 1'b0, a);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmb_drained: got %b want 0", busy); end
    endtask

    // Reference model: credits granted minus bursts completed, beats counted
    // modulo the burst length, every second accepted beat completes a word.
    task automatic test_random();
        logic          a, req, vd, af;
        logic [HW-1:0] d;
        int            credits = 0;
        int            beat_n  = 0;
        logic [HW-1:0] low     = '0;
        logic [DW-1:0] exp_word = '0;
        logic          exp_vd, exp_ack, exp_err;
        exp_err = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 2) == 0);
            af  = ($urandom_range(0, 5) == 0);
            vd  = (credits > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 60) == 0);
            d   = {$urandom, $urandom};
            exp_ack = req && (credits < MO) && !af;
            step(req, vd, d, af, a);
            checks++; if (a !== exp_ack) begin errors++; $display("FAIL rand_ack cyc %0d: got %b want %b", c, a, exp_ack); end
            exp_vd = 1'b0;
            if (vd && credits == 0) exp_err = 1'b1;
            if (vd && credits > 0) begin
                beat_n++;
                if (beat_n % 2 == 1) begin
                    low = d;
                end else begin
                    exp_word = {d, low};
                    exp_vd   = 1'b1;
                end
                if (beat_n == WB) begin
                    beat_n = 0;
                    credits--;
                end
            end
            if (exp_ack) credits++;
            checks++;
            if (rd_fifo_vd !== exp_vd || rd_fifo_in !== exp_word) begin
                errors++;
                $display("FAIL rand_word cyc %0d: got vd=%b %h want vd=%b %h", c, rd_fifo_vd, rd_fifo_in, exp_vd, exp_word);
            end
            checks++;
            if (busy !== (credits > 0) || rd_err !== exp_err) begin
                errors++;
                $display("FAIL rand_status cyc %0d: got busy=%b err=%b want busy=%b err=%b", c, busy, rd_err,
                         credits > 0, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_credit_limit();
        test_almost_full();
        test_ack_on_last();
        test_unsolicited();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
